aes_round_sequencer: RTL and testbench

Parametrised round sequencer for the iterative AES datapath in the XTS block engine. It supersedes the fixed 14-round controller and supports AES-128/192/256 round counts. It also adds encrypt/decrypt key-index ordering, back-to-back block acceptance, an output valid/acknowledge handshake with stall, and synchronous abort. It drives the round-register and output-register write enables and the round-key index for the key schedule RAM.

---
 rtl/aes_round_sequencer.sv | 128 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Round sequencer for the iterative AES datapath: counts rounds, orders
// round-key indices for encrypt/decrypt, and hands results off with stall.
//
// Ports:
//   inClk, inRstN      clock, synchronous active-low reset
//   inStart, inMode    new block request and its direction (1 = decrypt)
//   inAbort            drop the block in flight
//   inDataAck          downstream consumed the output register
//   outReady           a start is accepted this cycle
//   outRoundRegExtWr   load round register from the external bus
//   outRoundRegIntWr   load round register from round logic
//   outDataOutRegWr    capture final round result
//   outRoundIdx        round counter (0 = idle)
//   outKeyIdx          round-key index into the key schedule RAM
//   outLastRound       final round, MixColumns skipped
//   outMode            direction of the block in flight
//   outDataValid       output register holds an unconsumed result
//   outBusy            block in flight
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 14,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                 inClk,
    input  logic                 inRstN,
    input  logic                 inStart,
    input  logic                 inMode,
    input  logic                 inAbort,
    input  logic                 inDataAck,
    output logic                 outReady,
    output logic                 outRoundRegExtWr,
    output logic                 outRoundRegIntWr,
    output logic                 outDataOutRegWr,
    output logic [CNT_WIDTH-1:0] outRoundIdx,
    output logic [CNT_WIDTH-1:0] outKeyIdx,
    output logic                 outLastRound,
    output logic                 outMode,
    output logic                 outDataValid,
    output logic                 outBusy
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(NUM_ROUNDS);
    localparam logic [CNT_WIDTH-1:0] ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 mode;
    logic                 mode_next;
    logic                 valid;
    logic                 valid_next;

    logic idle;
    logic at_last;
    logic stall;
    logic finishing;
    logic ready;
    logic accept;
    logic out_wr;

    // Shared control terms used by both the next-state and output logic.
    assign idle      = (cnt == ZERO);
    assign at_last   = (cnt == LAST);
    assign stall     = at_last & valid & ~inDataAck;
    assign finishing = at_last & ~stall;
    // Ready never looks at inStart, so there is no start->ready loop.
    assign ready     = inRstN & ~inAbort & (idle | finishing);
    assign accept    = inStart & ready;
    assign out_wr    = finishing & ~inAbort;

    // State register.
    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            cnt   <= ZERO;
            mode  <= 1'b0;
            valid <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            mode  <= mode_next;
            valid <= valid_next;
        end
    end

    // Next-state logic: abort > stall > finish/start > increment.
    always_comb begin
        cnt_next   = cnt;
        mode_next  = mode;
        valid_next = valid;
        if (inAbort) begin
            cnt_next = ZERO;
        end else if (stall) begin
            cnt_next = cnt;
        end else if (at_last || idle) begin
            cnt_next = accept ? ONE : ZERO;
        end else begin
            cnt_next = cnt + ONE;
        end
        if (accept) begin
            mode_next = inMode;
        end
        // A write wins over a same-cycle ack: the new result is unconsumed.
        if (out_wr) begin
            valid_next = 1'b1;
        end else if (inDataAck) begin
            valid_next = 1'b0;
        end
    end

    // Output logic.
    always_comb begin
        outReady         = ready;
        outRoundRegExtWr = accept;
        outRoundRegIntWr = ~idle & ~stall & ~inAbort;
        outDataOutRegWr  = out_wr;
        outRoundIdx      = cnt;
        outLastRound     = at_last;
        outDataValid     = valid;
        outBusy          = ~idle;
        outMode          = idle ? inMode : mode;
        // While idle, the index serves the initial AddRoundKey of the
        // block being accepted, so it follows the incoming direction.
        if (idle) begin
            outKeyIdx = inMode ? LAST : ZERO;
        end else begin
            outKeyIdx = mode ? (LAST - cnt) : cnt;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: a vector table for reset and
// a single encrypt block, hand sequences for the multi-cycle corner cases.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       abort = 1'b0;
    logic       ack = 1'b0;
    logic       start10 = 1'b0;
    logic       mode10 = 1'b0;
    logic       ack10 = 1'b0;
    logic       abort10 = 1'b0;

    logic       ready, extwr, intwr, dowr, last, omode, valid, busy;
    logic [3:0] idx, key;
    logic       ready10, extwr10, intwr10, dowr10, last10, omode10;
    logic       valid10, busy10;
    logic [3:0] idx10, key10;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int sb[$];

    aes_round_sequencer #(.NUM_ROUNDS(14), .CNT_WIDTH(4)) dut14 (
        .inClk(clk), .inRstN(rstn), .inStart(start), .inMode(mode),
        .inAbort(abort), .inDataAck(ack), .outReady(ready),
        .outRoundRegExtWr(extwr), .outRoundRegIntWr(intwr),
        .outDataOutRegWr(dowr), .outRoundIdx(idx), .outKeyIdx(key),
        .outLastRound(last), .outMode(omode), .outDataValid(valid),
        .outBusy(busy)
    );

    aes_round_sequencer #(.NUM_ROUNDS(10), .CNT_WIDTH(4)) dut10 (
        .inClk(clk), .inRstN(rstn), .inStart(start10), .inMode(mode10),
        .inAbort(abort10), .inDataAck(ack10), .outReady(ready10),
        .outRoundRegExtWr(extwr10), .outRoundRegIntWr(intwr10),
        .outDataOutRegWr(dowr10), .outRoundIdx(idx10), .outKeyIdx(key10),
        .outLastRound(last10), .outMode(omode10), .outDataValid(valid10),
        .outBusy(busy10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int i, input int act,
                       input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0d expected %0d", nm, i, act, exp);
        end
    endtask

    // Scoreboard: every expected output-register write is queued with the
    // cycle it must occur in; any other write is flagged.
    always begin
        @(negedge clk);
        #2;
        if (dowr) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_wr cycle %0d", cyc);
            end else begin
                chk("sb_finish", cyc, cyc, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic full;
        logic start, vmode, vack, vabort, vrstn;
        logic e_ready, e_ext, e_int, e_wr, e_last, e_valid, e_busy;
        int   e_idx, e_key;
    } vec_t;

    vec_t vt[18];

    initial begin
        // Reset cycle: only ready/extwr are defined while reset is low.
        vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        for (int k = 1; k <= 14; k++) begin
            vt[2+k] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                        (k == 14), 1'b0, 1'b1, (k == 14), (k == 14),
                        1'b0, 1'b1, k, k};
        end
        vt[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};

        // Reset and a single 14-round encrypt block.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rstn = vt[i].vrstn;
            start = vt[i].start;
            mode = vt[i].vmode;
            ack = vt[i].vack;
            abort = vt[i].vabort;
            if (vt[i].start && vt[i].e_ext) sb.push_back(cyc + 14);
            #1;
            chk("vec_ready", i, int'(ready), int'(vt[i].e_ready));
            chk("vec_extwr", i, int'(extwr), int'(vt[i].e_ext));
            if (vt[i].full) begin
                chk("vec_intwr", i, int'(intwr), int'(vt[i].e_int));
                chk("vec_dowr", i, int'(dowr), int'(vt[i].e_wr));
                chk("vec_idx", i, int'(idx), vt[i].e_idx);
                chk("vec_key", i, int'(key), vt[i].e_key);
                chk("vec_last", i, int'(last), int'(vt[i].e_last));
                chk("vec_valid", i, int'(valid), int'(vt[i].e_valid));
                chk("vec_busy", i, int'(busy), int'(vt[i].e_busy));
            end
        end

        // 10-round decrypt on the second instance.
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
            start10 = (k == 0);
            mode10 = 1'b1;
            #1;
            if (k == 0) begin
                chk("dec_extwr", k, int'(extwr10), 1);
                chk("dec_key", k, int'(key10), 10);
            end else if (k <= 10) begin
                chk("dec_key", k, int'(key10), 10 - k);
                chk("dec_last", k, int'(last10), int'(k == 10));
                chk("dec_dowr", k, int'(dowr10), int'(k == 10));
            end else begin
                chk("dec_valid", k, int'(valid10), 1);
                chk("dec_busy", k, int'(busy10), 0);
            end
        end

        // Back-to-back blocks with ack tied high and start held.
        for (int t = 0; t <= 43; t++) begin
            @(negedge clk);
            start = (t <= 28);
            mode = 1'b0;
            ack = 1'b1;
            if (t == 0 || t == 14 || t == 28) sb.push_back(cyc + 14);
            #1;
            chk("b2b_idx", t, int'(idx),
                (t == 0 || t == 43) ? 0 : ((t - 1) % 14) + 1);
            chk("b2b_dowr", t, int'(dowr), int'(t > 0 && t % 14 == 0));
            if (t >= 1 && t <= 42) chk("b2b_busy", t, int'(busy), 1);
        end

        // Stall: second block reaches round 14 while the first result
        // is still unconsumed; ack is withheld for three cycles.
        for (int s = 0; s <= 33; s++) begin
            @(negedge clk);
            start = (s == 0 || s == 14);
            ack = (s == 31 || s == 32);
            if (s == 0) sb.push_back(cyc + 14);
            if (s == 14) sb.push_back(cyc + 17);
            #1;
            if (s >= 28 && s <= 30) begin
                chk("stall_idx", s, int'(idx), 14);
                chk("stall_intwr", s, int'(intwr), 0);
                chk("stall_dowr", s, int'(dowr), 0);
                chk("stall_ready", s, int'(ready), 0);
            end
            if (s == 31) begin
                chk("stall_ack_dowr", s, int'(dowr), 1);
                chk("stall_ack_ready", s, int'(ready), 1);
            end
            if (s == 32) begin
                chk("stall_valid_kept", s, int'(valid), 1);
                chk("stall_idx_end", s, int'(idx), 0);
            end
            if (s == 33) chk("stall_valid_clr", s, int'(valid), 0);
        end

        // Abort at round 7 with a pending result and a start in the
        // abort cycle.
        for (int a = 0; a <= 24; a++) begin
            @(negedge clk);
            start = (a == 0 || a == 15 || a == 22);
            abort = (a == 22);
            ack = 1'b0;
            if (a == 0) sb.push_back(cyc + 14);
            #1;
            if (a == 22) begin
                chk("abort_idx", a, int'(idx), 7);
                chk("abort_ready", a, int'(ready), 0);
                chk("abort_extwr", a, int'(extwr), 0);
                chk("abort_intwr", a, int'(intwr), 0);
                chk("abort_dowr", a, int'(dowr), 0);
            end
            if (a >= 23) begin
                chk("abort_idx_after", a, int'(idx), 0);
                chk("abort_valid", a, int'(valid), 1);
                chk("abort_busy", a, int'(busy), 0);
            end
        end
        abort = 1'b0;

        // Synchronous reset at round 9 with a pending result.
        for (int e = 0; e <= 10; e++) begin
            @(negedge clk);
            start = (e == 0 || e == 9);
            rstn = (e != 9);
            #1;
            if (e == 9) begin
                chk("rst_idx_before", e, int'(idx), 9);
                chk("rst_valid_before", e, int'(valid), 1);
                chk("rst_ready", e, int'(ready), 0);
                chk("rst_extwr", e, int'(extwr), 0);
            end
            if (e == 10) begin
                chk("rst_idx", e, int'(idx), 0);
                chk("rst_valid", e, int'(valid), 0);
                chk("rst_busy", e, int'(busy), 0);
            end
        end

        @(negedge clk);
        start = 1'b0;
        #3;
        chk("sb_drained", 0, sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
